// File: rtl/shared_net_arbiter.sv
// Round-robin arbiter for one shared output net. One requester owns the net
// at a time; its data slice is muxed onto bus_out and its tenure is capped
// at MAX_HOLD cycles (0 = no cap). A one-cycle idle gap separates grants so
// the priority pointer can advance past the previous owner.
//
// state | meaning
// IDLE  | no grant active; arbitrate among req starting at ptr
// GRANT | gnt_id owns the net; watch for release, drop or hold cap
module shared_net_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         rel,
  input  logic [N_REQ*DATA_W-1:0]  din,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     busy,
  output logic [DATA_W-1:0]        bus_out,
  output logic                     timeout
);

  localparam int IDW = $clog2(N_REQ);
  localparam int HW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  // With no cap the counter parks at 0; the cap compare is disabled anyway.
  localparam logic [HW-1:0]    HLAST   = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
  localparam logic [IDW-1:0]   LAST_ID = IDW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE     = N_REQ'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [HW-1:0]   hcnt;
  logic [IDW-1:0]  win;
  logic            found;
  int              idx;
  logic            owner_rel;
  logic            owner_drop;
  logic            hold_end;

  // Winner search: first requester at or after ptr, wrapping modulo N_REQ
  // without needing N_REQ to be a power of two.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // End-of-tenure conditions for the current owner only.
  always_comb begin
    owner_rel  = rel[gnt_id];
    owner_drop = !req[gnt_id];
    hold_end   = (MAX_HOLD != 0) && (hcnt == HLAST);
  end

  // Arbitration FSM with registered grant, id and timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      ptr     <= '0;
      hcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt    <= ONE << win;
            gnt_id <= win;
            hcnt   <= '0;
            state  <= GRANT;
          end
        end
        GRANT: begin
          if (hcnt != HLAST) hcnt <= hcnt + 1'b1;
          if (owner_rel || owner_drop || hold_end) begin
            gnt     <= '0;
            state   <= IDLE;
            ptr     <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
            timeout <= hold_end && !owner_rel && !owner_drop;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = |gnt;

  // Net mux keyed on the one-hot grant so an idle net reads as zero.
  always_comb begin
    bus_out = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) bus_out = din[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_shared_net_arbiter.sv
// Directed bench for shared_net_arbiter: a 4-requester capped instance and a
// 3-requester uncapped instance sharing clock and reset.
module tb_shared_net_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, rel;
  logic [15:0] din;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        busy, timeout;
  logic [3:0]  bus_out;

  logic [2:0]  req3, rel3;
  logic [11:0] din3;
  logic [2:0]  gnt3;
  logic [1:0]  gnt_id3;
  logic        busy3, timeout3;
  logic [3:0]  bus_out3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shared_net_arbiter #(.N_REQ(4), .DATA_W(4), .MAX_HOLD(8)) u_dut (
    .clk(clk), .rst(rst), .req(req), .rel(rel), .din(din),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .bus_out(bus_out), .timeout(timeout)
  );

  shared_net_arbiter #(.N_REQ(3), .DATA_W(4), .MAX_HOLD(0)) u_dut3 (
    .clk(clk), .rst(rst), .req(req3), .rel(rel3), .din(din3),
    .gnt(gnt3), .gnt_id(gnt_id3), .busy(busy3), .bus_out(bus_out3), .timeout(timeout3)
  );

  // Expected {gnt, gnt_id, busy, bus_out, timeout}; data slice i holds 4'hA+i.
  function automatic logic [11:0] exp4(input logic act, input int id, input logic to);
    logic [3:0] g, b;
    g = act ? (4'b0001 << id) : 4'b0000;
    b = act ? 4'(10 + id) : 4'h0;
    return {g, 2'(id), act, b, to};
  endfunction

  // Same layout for the 3-requester instance; data slice i holds 4'h7+i.
  function automatic logic [10:0] exp3(input logic act, input int id, input logic to);
    logic [2:0] g;
    logic [3:0] b;
    g = act ? (3'b001 << id) : 3'b000;
    b = act ? 4'(7 + id) : 4'h0;
    return {g, 2'(id), act, b, to};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {gnt,id,busy,bus,to}=%h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] rel;
    logic       act;
    int         id;
    logic       to;
  } vec_t;

  vec_t vt[15];
  int   hold3[4];

  initial begin
    vt[0]  = '{4'b0100, 4'b0000, 1'b1, 2, 1'b0};  // single request, 1-cycle latency
    vt[1]  = '{4'b0000, 4'b0000, 1'b0, 2, 1'b0};  // req drop ends grant, id held
    vt[2]  = '{4'b1000, 4'b0000, 1'b1, 3, 1'b0};  // ptr=3 -> grant 3
    vt[3]  = '{4'b1000, 4'b0100, 1'b1, 3, 1'b0};  // rel of non-owner ignored
    vt[4]  = '{4'b0001, 4'b0000, 1'b0, 3, 1'b0};  // owner drops req, ptr wraps to 0
    vt[5]  = '{4'b1001, 4'b0000, 1'b1, 0, 1'b0};  // from ptr=0 -> 0 beats 3
    vt[6]  = '{4'b0000, 4'b0000, 1'b0, 0, 1'b0};
    vt[7]  = '{4'b0010, 4'b0000, 1'b1, 1, 1'b0};  // granted cycle 1
    vt[8]  = '{4'b0010, 4'b0000, 1'b1, 1, 1'b0};  // granted cycle 2
    vt[9]  = '{4'b0110, 4'b0000, 1'b1, 1, 1'b0};  // granted cycle 3
    vt[10] = '{4'b0110, 4'b1010, 1'b0, 1, 1'b0};  // rel[1] ends, no timeout
    vt[11] = '{4'b0111, 4'b0000, 1'b1, 2, 1'b0};  // ptr=2 -> grant 2
    vt[12] = '{4'b0111, 4'b1011, 1'b1, 2, 1'b0};  // others' rel ignored
    vt[13] = '{4'b0000, 4'b0000, 1'b0, 2, 1'b0};
    vt[14] = '{4'b0000, 4'b1111, 1'b0, 2, 1'b0};  // rel while idle ignored
    hold3  = '{12, 5, 5, 5};

    din  = {4'hD, 4'hC, 4'hB, 4'hA};
    din3 = {4'h9, 4'h8, 4'h7};
    req = '0; rel = '0; req3 = '0; rel3 = '0;

    // Reset state
    rst = 1'b1;
    #2;
    chk("reset", {gnt, gnt_id, busy, bus_out, timeout}, exp4(1'b0, 0, 1'b0));
    chk("reset3", {1'b0, gnt3, gnt_id3, busy3, bus_out3, timeout3}, {1'b0, exp3(1'b0, 0, 1'b0)});
    @(negedge clk);
    rst = 1'b0;

    // Table-driven single-cycle behaviour
    for (int v = 0; v < 15; v++) begin
      req = vt[v].req;
      rel = vt[v].rel;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", v), {gnt, gnt_id, busy, bus_out, timeout},
          exp4(vt[v].act, vt[v].id, vt[v].to));
    end
    rel = '0;

    // All requesting: 8-cycle tenures, 1-cycle gap carrying the timeout pulse
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 8; c++) begin
        @(posedge clk); #1;
        chk($sformatf("rr g%0d c%0d", g, c), {gnt, gnt_id, busy, bus_out, timeout},
            exp4(1'b1, g % 4, 1'b0));
      end
      @(posedge clk); #1;
      chk($sformatf("rr gap%0d", g), {gnt, gnt_id, busy, bus_out, timeout},
          exp4(1'b0, g % 4, 1'b1));
    end

    // Asynchronous reset in the middle of a grant
    req = 4'b1000;
    @(posedge clk); #1;
    chk("pre-rst grant3", {gnt, gnt_id, busy, bus_out, timeout}, exp4(1'b1, 3, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    chk("async rst", {gnt, gnt_id, busy, bus_out, timeout}, exp4(1'b0, 0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0010;
    @(posedge clk); #1;
    chk("post-rst grant1", {gnt, gnt_id, busy, bus_out, timeout}, exp4(1'b1, 1, 1'b0));
    req = 4'b0000;
    @(posedge clk); #1;
    chk("post-rst idle", {gnt, gnt_id, busy, bus_out, timeout}, exp4(1'b0, 1, 1'b0));

    // Uncapped 3-requester instance: order 0,1,2,0, never a timeout
    do_reset();
    req3 = 3'b111;
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < hold3[g]; c++) begin
        @(posedge clk); #1;
        chk($sformatf("n3 g%0d c%0d", g, c),
            {1'b0, gnt3, gnt_id3, busy3, bus_out3, timeout3}, {1'b0, exp3(1'b1, g % 3, 1'b0)});
        if (c == hold3[g] - 1) rel3 = 3'b001 << (g % 3);
      end
      @(posedge clk); #1;
      rel3 = 3'b000;
      chk($sformatf("n3 gap%0d", g),
          {1'b0, gnt3, gnt_id3, busy3, bus_out3, timeout3}, {1'b0, exp3(1'b0, g % 3, 1'b0)});
    end
    req3 = 3'b000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
